// File: rtl/div_if.sv
// Divide request/response bundle between the EX stage and the iterative
// divider. Build macro: DIV_BYZERO_FLAG_EN adds div_by_zero_o.
//
// Handshake: EX raises start_i with operands and signed_div_i and keeps them
// steady until it sees ready_o=1. The divider samples the operands only on
// the edge that accepts the request. It then holds ready_o/result_o stable
// for as long as start_i stays high. EX drops start_i in the cycle it
// consumes ready_o. annul_i aborts an operation while it is still iterating.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic [1:0]         dbg_state;
`ifdef DIV_BYZERO_FLAG_EN
  logic               div_by_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbg_state, div_by_zero_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbg_state, div_by_zero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbg_state
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbg_state
  );
`endif
endinterface

// File: rtl/div_radix2.sv
// Radix-2 restoring divider, one quotient bit per clock. It produces
// {remainder, quotient} for DIV/DIVU. Signed operands are divided as
// magnitudes, and the signs are applied when the result is written.
// Build macro: DIV_BYZERO_FLAG_EN adds a registered div_by_zero_o flag.
module div_radix2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // {partial remainder, dividend} window. In the 2W+1 bit view, the top bit
  // is always zero between steps because remainder < divisor. Only the low
  // 2W bits are stored.
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   divisor;
  logic               q_neg;
  logic               r_neg;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] stepped;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic               neg1;
  logic               neg2;

  // Per-cycle work: one restoring step, sign fix-up, and operand magnitudes.
  always_comb begin
    trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    if (trial[WIDTH]) begin
      stepped = {work[2*WIDTH-2:0], 1'b0};
    end else begin
      stepped = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end
    quo_fix = q_neg ? -stepped[WIDTH-1:0] : stepped[WIDTH-1:0];
    rem_fix = r_neg ? -stepped[2*WIDTH-1:WIDTH] : stepped[2*WIDTH-1:WIDTH];
    neg1    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    neg2    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1    = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = neg2 ? -bus.opdata2_i : bus.opdata2_i;
  end

`ifdef DIV_BYZERO_FLAG_EN
  logic dbz_q;
  assign bus.div_by_zero_o = dbz_q;
`endif

  // Control FSM and datapath registers. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
`ifdef DIV_BYZERO_FLAG_EN
      dbz_q    <= 1'b0;
`endif
    end else begin
      case (state)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
`ifdef DIV_BYZERO_FLAG_EN
          dbz_q    <= 1'b0;
`endif
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              work    <= {{WIDTH{1'b0}}, abs1};
              divisor <= abs2;
              q_neg   <= neg1 ^ neg2;
              r_neg   <= neg1;
            end
          end
        end
        BYZERO: begin
          state    <= END;
          ready_q  <= 1'b1;
          result_q <= '0;
`ifdef DIV_BYZERO_FLAG_EN
          dbz_q    <= 1'b1;
`endif
        end
        ON: begin
          if (bus.annul_i) begin
            state    <= FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end else begin
            work <= stepped;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state    <= END;
              ready_q  <= 1'b1;
              result_q <= {rem_fix, quo_fix};
            end
          end
        end
        END: begin
          if (!bus.start_i) begin
            state    <= FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
`ifdef DIV_BYZERO_FLAG_EN
            dbz_q    <= 1'b0;
`endif
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.result_o  = result_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: operand table, annul, reset mid-operation,
// simultaneous start/annul, with an arithmetic reference model.
module tb_div_radix2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus ();
  div_radix2 #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic           exp_dbz_q[$];
  logic           ready_prev = 1'b0;
  logic [2*W-1:0] held = '0;

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Clock/reset and global timeout.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Compare process: checks the outputs against the model queue on every cycle.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    logic           ed;
    if (!rst) begin
      if (!bus.ready_o) begin
        check("idle_result", bus.result_o, '0);
`ifdef DIV_BYZERO_FLAG_EN
        check("idle_dbz", {63'b0, bus.div_by_zero_o}, '0);
`endif
      end else if (!ready_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready=1 want no pending op");
        end else begin
          e  = exp_q.pop_front();
          ed = exp_dbz_q.pop_front();
          check("result", bus.result_o, e);
`ifdef DIV_BYZERO_FLAG_EN
          check("dbz_flag", {63'b0, bus.div_by_zero_o}, {63'b0, ed});
`endif
        end
      end else begin
        check("hold", bus.result_o, held);
      end
    end
    ready_prev <= rst ? 1'b0 : bus.ready_o;
    held       <= bus.result_o;
  end

  // Driver: present a request and let the next rising edge accept it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.start_i      = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    exp_dbz_q.push_back(b == '0);
    @(posedge clk);
  endtask

  // Driver: count edges from the accept until ready, hold start, then release.
  task automatic finish_op(input int lat, input string name);
    int edges = 1;
    @(negedge clk);
    while (!bus.ready_o && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({name, "_latency"}, 64'(edges), 64'(lat));
    repeat (2) @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_drop_ready"}, {63'b0, bus.ready_o}, '0);
    check({name, "_drop_result"}, bus.result_o, '0);
  endtask

  logic [W-1:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h80000000,
                           32'hFFFFFFFF, 32'hFFFFFF9C};
  logic [W-1:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF,
                           32'd1, 32'hFFFFFFF9};
  logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;

    // Hand-computed pins of the reference model.
    check("pin_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("pin_m7_2", model(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
    check("pin_7_m2", model(32'd7, 32'hFFFFFFFE, 1'b1), {32'h00000001, 32'hFFFFFFFD});
    check("pin_min_m1", model(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});
    check("pin_max_1", model(32'hFFFFFFFF, 32'd1, 1'b0), {32'h0, 32'hFFFFFFFF});
    check("pin_9_3", model(32'd9, 32'd3, 1'b0), {32'd0, 32'd3});
    check("pin_by0", model(32'h1234, 32'd0, 1'b0), '0);
    check("pin_m100_m7", model(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1), {32'hFFFFFFFE, 32'd14});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {63'b0, bus.ready_o}, '0);
    check("reset_result", bus.result_o, '0);
    rst = 1'b0;

    // Operand table: unsigned, signed, divide-by-zero, overflow corner, max.
    for (int i = 0; i < 7; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      finish_op((tb[i] == '0) ? 2 : W + 1, $sformatf("op%0d", i));
    end

    // Annul after 10 iterations, then a fresh 9 / 3.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_dbz_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    check("annul_ready", {63'b0, bus.ready_o}, '0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("annul_never_ready", {63'b0, bus.ready_o}, '0);
    start_op(32'd9, 32'd3, 1'b0);
    finish_op(W + 1, "after_annul");

    // Reset at iteration 20 with start held; the held request restarts in full.
    start_op(32'hDEADBEEF, 32'h1234, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_dbz_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("midreset_ready", {63'b0, bus.ready_o}, '0);
    check("midreset_result", bus.result_o, '0);
    rst = 1'b0;
    exp_q.push_back(model(32'hDEADBEEF, 32'h1234, 1'b0));
    exp_dbz_q.push_back(1'b0);
    @(posedge clk);
    finish_op(W + 1, "after_reset");

    // Start and annul together in FREE: not accepted until annul drops.
    @(negedge clk);
    bus.opdata1_i    = 32'h12345678;
    bus.opdata2_i    = 32'h10;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("start_annul_free", {63'b0, bus.ready_o}, '0);
    bus.annul_i = 1'b0;
    exp_q.push_back({32'h8, 32'h01234567});
    exp_dbz_q.push_back(1'b0);
    @(posedge clk);
    finish_op(W + 1, "start_annul");

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
